// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with PC, ROM drive and a 2-entry {pc, inst} output buffer.
// Optional halt detection on HALT_INST is compiled in with `define FETCH_HALT_EN.
`default_nettype none

module fetch_ctrl #(
  parameter int                ADDR_W    = 6,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [31:0]       br_target,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              rom_ce_q;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_pc_q   [2];
  logic [INST_W-1:0] fifo_inst_q [2];
  logic              push, pop, halt_hit;
  logic              unused_tgt;

  assign unused_tgt = ^br_target[1:0];

  assign pop  = (count_q != 2'd0) && out_ready;
  assign push = (state_q == S_FETCH) && !stall && !br_valid && ((count_q != 2'd2) || pop);

`ifdef FETCH_HALT_EN
  assign halt_hit = push && (rom_inst == HALT_INST);
`else
  logic unused_halt;
  assign unused_halt = ^HALT_INST;
  assign halt_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (halt_hit) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // A redirect flushes the buffer, including any head popped this same cycle.
    if (br_valid) begin
      state_d  = S_FETCH;
      pc_d     = {br_target[31:2], 2'b00};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 32'd0;
      rom_ce_q <= 1'b0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]   <= 32'd0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rom_ce_q <= (state_d == S_FETCH);
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= pc_q;
        fifo_inst_q[wr_ptr_q] <= rom_inst;
      end
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= (state_d == S_HALT);
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign rom_ce    = rom_ce_q;
  assign rom_addr  = pc_q[ADDR_W+1:2];
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_inst  = fifo_inst_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, self-checking bench for fetch_ctrl with a combinational ROM model.
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
  logic        halted;

  logic [31:0] rom [64];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr];

  fetch_ctrl #(.ADDR_W(6), .INST_W(32), .HALT_INST(32'hFFFF_FFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .halted    (halted)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;

    // Reset state
    #2;
    check("rst_rom_ce",    32'(rom_ce),    32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);

    // Streaming, no bubbles
    out_ready = 1'b1;
    do_reset();
    tick();
    check("s_e1_rom_ce", 32'(rom_ce),    32'd1);
    check("s_e1_valid",  32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_pc",    out_pc,         32'(4 * k));
      check("s_inst",  out_inst,       32'h1000_0000 + 32'(k));
    end

    // Backpressure: buffer fills to 2, pc holds at 8
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    check("bp_valid",    32'(out_valid), 32'd1);
    check("bp_head",     out_pc,         32'd0);
    check("bp_rom_addr", 32'(rom_addr),  32'd2);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("bp_drain_pc", out_pc, 32'(4 * k));
    end

    // Branch while full, also overriding stall
    out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("br_full_head", out_pc, 32'd0);
    br_valid  = 1'b1;
    br_target = 32'h0000_0023;
    stall     = 1'b1;
    tick();
    br_valid = 1'b0;
    stall    = 1'b0;
    check("br_bubble",   32'(out_valid), 32'd0);
    check("br_rom_addr", 32'(rom_addr),  32'd8);
    out_ready = 1'b1;
    tick();
    check("br_valid_1", 32'(out_valid), 32'd1);
    check("br_pc_1",    out_pc,         32'h20);
    check("br_inst_1",  out_inst,       32'h1000_0008);
    tick();
    check("br_pc_2",    out_pc,         32'h24);

    // Stall: drain, pc frozen, then resume without skipping
    out_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    check("st_pre_pc", out_pc, 32'h4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_valid",    32'(out_valid), 32'd0);
      check("st_rom_addr", 32'(rom_addr),  32'd2);
    end
    stall = 1'b0;
    tick();
    check("st_res_valid", 32'(out_valid), 32'd1);
    check("st_res_pc",    out_pc,         32'h8);
    tick();
    check("st_res_pc2",   out_pc,         32'hC);

    // Halt word at ROM word 3
    rom[3]    = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    check("h_pc",   out_pc,   32'hC);
    check("h_inst", out_inst, 32'hFFFF_FFFF);
`ifdef FETCH_HALT_EN
    check("h_rom_ce", 32'(rom_ce), 32'd0);
    check("h_halted", 32'(halted), 32'd1);
    tick();
    check("h_drained",  32'(out_valid), 32'd0);
    check("h_rom_ce2",  32'(rom_ce),    32'd0);
    check("h_halted2",  32'(halted),    32'd1);
`else
    check("h_rom_ce", 32'(rom_ce), 32'd1);
    check("h_halted", 32'(halted), 32'd0);
    tick();
    check("h_next_pc",  out_pc,         32'h10);
    check("h_next_val", 32'(out_valid), 32'd1);
`endif
    br_valid  = 1'b1;
    br_target = 32'd0;
    tick();
    br_valid = 1'b0;
    check("h_br_halted", 32'(halted),    32'd0);
    check("h_br_rom_ce", 32'(rom_ce),    32'd1);
    check("h_br_valid",  32'(out_valid), 32'd0);
    tick();
    check("h_re_pc",   out_pc,   32'd0);
    check("h_re_inst", out_inst, 32'h1000_0000);
    rom[3] = 32'h1000_0003;

    // Asynchronous reset mid-burst with buffer full
    out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_rom_ce",   32'(rom_ce),    32'd0);
    check("ar_valid",    32'(out_valid), 32'd0);
    check("ar_halted",   32'(halted),    32'd0);
    check("ar_rom_addr", 32'(rom_addr),  32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("ar_re_valid", 32'(out_valid), 32'd1);
    check("ar_re_pc",    out_pc,         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
